// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the serial binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ZERO_DIGIT = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= BCD_ADJ_THRESH) adj_c = digit + BCD_ADJ_ADD;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Serial shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_LZB_EN to add the blank_n leading-zero blanking mask output.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          ovf
`ifdef BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]             blank_n
`endif
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               carry_q, carry_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               in_ready_q, in_ready_d;

  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   scratch_sh_c;
  logic               carry_out_c;
  logic               accept_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj_c (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Adjusted digits shifted left, next binary MSB entering the units LSB.
  assign scratch_sh_c = {adj_c[BCD_W-2:0], shift_q[BIN_W-1]};
  assign carry_out_c  = adj_c[BCD_W-1];
  assign accept_c     = in_valid & in_ready_q;

`ifdef BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_nxt_c;
  logic              lzb_nz_c;

  // A digit stays lit once it or any higher digit is non-zero.
  always_comb begin
    lzb_nz_c       = 1'b0;
    blank_nxt_c    = '0;
    blank_nxt_c[0] = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      lzb_nz_c       = lzb_nz_c | (scratch_sh_c[k*BCD_DIGIT_W +: BCD_DIGIT_W] != BCD_ZERO_DIGIT);
      blank_nxt_c[k] = lzb_nz_c;
    end
  end

  assign blank_n = blank_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    carry_d   = carry_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef BCD_LZB_EN
    blank_d   = blank_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          state_d   = ST_SHIFT;
          shift_d   = bin_in;
          scratch_d = {DIGITS{BCD_ZERO_DIGIT}};
          cnt_d     = CNT_W'(BIN_W - 1);
          carry_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        shift_d   = {shift_q[BIN_W-2:0], 1'b0};
        scratch_d = scratch_sh_c;
        carry_d   = carry_q | carry_out_c;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          bcd_d   = scratch_sh_c;
          ovf_d   = carry_q | carry_out_c;
`ifdef BCD_LZB_EN
          blank_d = blank_nxt_c;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d != ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      scratch_q  <= '0;
      carry_q    <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
`ifdef BCD_LZB_EN
      blank_q    <= DIGITS'(1);
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      carry_q    <= carry_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
`ifdef BCD_LZB_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench: decimal reference model compared every cycle, plus literal spot checks.
module tb_bcd_seq_converter;

  localparam int BIN_W = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  bin_in;
  logic        in_ready, in_ready2;
  logic        done, done2;
  logic [11:0] bcd_out;
  logic [7:0]  bcd_out2;
  logic        ovf, ovf2;
`ifdef BCD_LZB_EN
  logic [2:0]  blank_n;
  logic [1:0]  blank_n2;
`endif

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bin_in   (bin_in),
    .done     (done),
    .bcd_out  (bcd_out),
    .ovf      (ovf)
`ifdef BCD_LZB_EN
    ,
    .blank_n  (blank_n)
`endif
  );

  bcd_seq_converter #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready2),
    .bin_in   (bin_in),
    .done     (done2),
    .bcd_out  (bcd_out2),
    .ovf      (ovf2)
`ifdef BCD_LZB_EN
    ,
    .blank_n  (blank_n2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] blank_of(input int v, input int nd);
    logic [31:0] r = '0;
    int m = v % p10(nd);
    for (int k = 0; k < nd; k++) r[k] = (k == 0) || (m >= p10(k));
    return r;
  endfunction

  // Reference model: a conversion takes BIN_W cycles after accept, result appears on done.
  logic        m_init = 1'b0;
  logic        m_ready, m_done, m_ovf, m_ovf2;
  logic [31:0] m_bcd, m_bcd2, m_blank, m_blank2;
  int          m_left, m_val, m_ndone;
  initial m_ndone = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init   = 1'b1;
      m_ready  = 1'b1;
      m_done   = 1'b0;
      m_left   = 0;
      m_bcd    = '0;
      m_bcd2   = '0;
      m_ovf    = 1'b0;
      m_ovf2   = 1'b0;
      m_blank  = 32'd1;
      m_blank2 = 32'd1;
    end else if (m_init) begin
      logic acc;
      acc    = in_valid && m_ready;
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_ready  = 1'b1;
          m_bcd    = to_bcd(m_val, 3);
          m_ovf    = (m_val >= 1000);
          m_blank  = blank_of(m_val, 3);
          m_bcd2   = to_bcd(m_val, 2);
          m_ovf2   = (m_val >= 100);
          m_blank2 = blank_of(m_val, 2);
          m_ndone++;
        end
      end
      if (acc) begin
        m_val   = int'(bin_in);
        m_left  = BIN_W;
        m_ready = 1'b0;
      end
    end
  end

  int dut_done_cnt = 0;

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd_out", 32'(bcd_out), m_bcd);
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("in_ready2", 32'(in_ready2), 32'(m_ready));
      chk("done2", 32'(done2), 32'(m_done));
      chk("bcd_out2", 32'(bcd_out2), m_bcd2);
      chk("ovf2", 32'(ovf2), 32'(m_ovf2));
`ifdef BCD_LZB_EN
      chk("blank_n", 32'(blank_n), m_blank);
      chk("blank_n2", 32'(blank_n2), m_blank2);
`endif
      if (done) dut_done_cnt++;
    end
  end

  // Present v and hold until accepted; returns at the negedge of the first SHIFT cycle.
  task automatic send(input logic [7:0] v);
    int t = 0;
    bin_in   = v;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int start;
    int t;
    rst      = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (3) @(negedge clk);

    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
`ifdef BCD_LZB_EN
    chk("rst_blank", 32'(blank_n), 32'b001);
`endif
    rst = 1'b0;
    idle(2);

    // Zero converts in exactly BIN_W+1 cycles.
    send(8'd0);
    wait_done(1, lat);
    chk("lat_0", 32'(lat), 32'd9);
    chk("bcd_0", 32'(bcd_out), 32'h000);
    chk("ovf_0", 32'(ovf), 32'd0);
`ifdef BCD_LZB_EN
    chk("blank_0", 32'(blank_n), 32'b001);
`endif
    idle(2);

    send(8'd255);
    wait_done(1, lat);
    chk("lat_255", 32'(lat), 32'd9);
    chk("bcd_255", 32'(bcd_out), 32'h255);
    chk("bcd2_255", 32'(bcd_out2), 32'h55);
    chk("ovf2_255", 32'(ovf2), 32'd1);
`ifdef BCD_LZB_EN
    chk("blank_255", 32'(blank_n), 32'b111);
`endif
    idle(1);

    send(8'd99);
    wait_done(1, lat);
    chk("bcd_99", 32'(bcd_out), 32'h099);
    chk("bcd2_99", 32'(bcd_out2), 32'h99);
    chk("ovf2_99", 32'(ovf2), 32'd0);
`ifdef BCD_LZB_EN
    chk("blank_99", 32'(blank_n), 32'b011);
    chk("blank2_99", 32'(blank_n2), 32'b11);
`endif
    idle(1);

    send(8'd200);
    wait_done(1, lat);
    chk("bcd2_200", 32'(bcd_out2), 32'h00);
    chk("ovf2_200", 32'(ovf2), 32'd1);
    chk("bcd_200", 32'(bcd_out), 32'h200);
    idle(2);

    // Back-to-back sweep, every accept lands in the DONE cycle.
    start = dut_done_cnt;
    for (int v = 0; v < 256; v++) begin
      bin_in   = 8'(v);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("sweep_accept_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle(12);
    chk("sweep_done_count", 32'(dut_done_cnt - start), 32'd256);

    // Requests during SHIFT are dropped.
    start = dut_done_cnt;
    send(8'd128);
    @(negedge clk); in_valid = 1'b1; bin_in = 8'd7;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    wait_done(5, lat);
    chk("lat_128", 32'(lat), 32'd9);
    chk("bcd_128", 32'(bcd_out), 32'h128);
    idle(12);
    chk("ignored_done_count", 32'(dut_done_cnt - start), 32'd1);

    // Reset mid-conversion discards the partial result.
    start = dut_done_cnt;
    send(8'd200);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bcd", 32'(bcd_out), 32'h000);
    chk("abort_ready", 32'(in_ready), 32'd1);
    idle(12);
    chk("abort_no_done", 32'(dut_done_cnt - start), 32'd0);
    send(8'd42);
    wait_done(1, lat);
    chk("bcd_42", 32'(bcd_out), 32'h042);
    chk("bcd2_42", 32'(bcd_out2), 32'h42);
`ifdef BCD_LZB_EN
    chk("blank_42", 32'(blank_n), 32'b011);
`endif
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      bin_in   = 8'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(12);
    chk("total_done_count", 32'(dut_done_cnt), 32'(m_ndone));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
